// File: rtl/ym_bus_master.sv
// Register-write engine for the YM2612 CPU bus: address write, data write, then busy poll.
// One 12-bit down-counter times every phase; all outputs are registered.
module ym_bus_master #(
   parameter int unsigned SETUP_CYCLES  = 6,
   parameter int unsigned STROBE_CYCLES = 12,
   parameter int unsigned HOLD_CYCLES   = 6,
   parameter int unsigned BUSY_WAIT     = 12,
   parameter int unsigned TIMEOUT       = 4095
) (
   input  logic       clk50,
   input  logic       rst_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_port,
   input  logic [7:0] req_reg,
   input  logic [7:0] req_data,
   output logic [7:0] ym_din,
   output logic [1:0] ym_addr,
   output logic       ym_cs_n,
   output logic       ym_wr_n,
   input  logic [7:0] ym_dout,
   output logic       err_timeout,
   output logic [7:0] err_count
);

   localparam int unsigned CNT_W = 12;
   localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] WAIT_LD   = CNT_W'(BUSY_WAIT - 1);
   localparam logic [CNT_W-1:0] POLL_LD   = CNT_W'(TIMEOUT - 1);
   // Data setup carries one extra leading cycle: the cs_n-high gap between the two writes.
   localparam logic [CNT_W-1:0] GAP_LD    = CNT_W'(SETUP_CYCLES);

   typedef enum logic [3:0] {
      IDLE, A_SETUP, A_STROBE, A_HOLD, D_SETUP, D_STROBE, D_HOLD, WAIT, POLL
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             port_q;
   logic [7:0]       data_q;
   logic             cnt_zero;
   logic             busy;

   assign cnt_zero = (cnt == '0);
   assign busy     = ym_dout[7];

   // Only the busy flag of the status byte matters.
   logic unused_dout;
   assign unused_dout = ^ym_dout[6:0];

   always_ff @(posedge clk50 or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         port_q      <= 1'b0;
         data_q      <= 8'h00;
         req_ready   <= 1'b1;
         ym_din      <= 8'h00;
         ym_addr     <= 2'b00;
         ym_cs_n     <= 1'b1;
         ym_wr_n     <= 1'b1;
         err_timeout <= 1'b0;
         err_count   <= 8'h00;
      end else begin
         err_timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  port_q    <= req_port;
                  data_q    <= req_data;
                  ym_addr   <= {req_port, 1'b0};
                  ym_din    <= req_reg;
                  ym_cs_n   <= 1'b0;
                  req_ready <= 1'b0;
                  cnt       <= SETUP_LD;
                  state     <= A_SETUP;
               end
            end
            A_SETUP: begin
               if (cnt_zero) begin
                  ym_wr_n <= 1'b0;
                  cnt     <= STROBE_LD;
                  state   <= A_STROBE;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            A_STROBE: begin
               if (cnt_zero) begin
                  ym_wr_n <= 1'b1;
                  cnt     <= HOLD_LD;
                  state   <= A_HOLD;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            A_HOLD: begin
               if (cnt_zero) begin
                  ym_cs_n <= 1'b1;
                  ym_addr <= {port_q, 1'b1};
                  ym_din  <= data_q;
                  cnt     <= GAP_LD;
                  state   <= D_SETUP;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            D_SETUP: begin
               ym_cs_n <= 1'b0;
               if (cnt_zero) begin
                  ym_wr_n <= 1'b0;
                  cnt     <= STROBE_LD;
                  state   <= D_STROBE;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            D_STROBE: begin
               if (cnt_zero) begin
                  ym_wr_n <= 1'b1;
                  cnt     <= HOLD_LD;
                  state   <= D_HOLD;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            D_HOLD: begin
               if (cnt_zero) begin
                  ym_cs_n <= 1'b1;
                  cnt     <= WAIT_LD;
                  state   <= WAIT;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            WAIT: begin
               if (cnt_zero) begin
                  cnt   <= POLL_LD;
                  state <= POLL;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            POLL: begin
               if (!busy) begin
                  req_ready <= 1'b1;
                  state     <= IDLE;
               end else if (cnt_zero) begin
                  err_timeout <= 1'b1;
                  if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                  req_ready <= 1'b1;
                  state     <= IDLE;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: begin
               ym_cs_n   <= 1'b1;
               ym_wr_n   <= 1'b1;
               req_ready <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ym_bus_master.sv
// Directed bench: default-timing instance for bus shape/latency, minimal-timing instance for timeouts.
module tb_ym_bus_master;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance a: default timing
   logic       a_rst_n = 1'b1;
   logic       a_valid = 1'b0, a_port = 1'b0;
   logic [7:0] a_reg = 8'h00, a_data = 8'h00, a_dout = 8'h00;
   logic       a_ready, a_cs_n, a_wr_n, a_err;
   logic [7:0] a_din, a_errcnt;
   logic [1:0] a_addr;

   // Instance b: minimal phases, TIMEOUT=8
   logic       b_rst_n = 1'b1;
   logic       b_valid = 1'b0, b_port = 1'b0;
   logic [7:0] b_reg = 8'h00, b_data = 8'h00, b_dout = 8'h00;
   logic       b_ready, b_cs_n, b_wr_n, b_err;
   logic [7:0] b_din, b_errcnt;
   logic [1:0] b_addr;

   ym_bus_master u_a (
      .clk50(clk), .rst_n(a_rst_n), .req_valid(a_valid), .req_ready(a_ready),
      .req_port(a_port), .req_reg(a_reg), .req_data(a_data), .ym_din(a_din),
      .ym_addr(a_addr), .ym_cs_n(a_cs_n), .ym_wr_n(a_wr_n), .ym_dout(a_dout),
      .err_timeout(a_err), .err_count(a_errcnt)
   );

   ym_bus_master #(
      .SETUP_CYCLES(1), .STROBE_CYCLES(1), .HOLD_CYCLES(1), .BUSY_WAIT(1), .TIMEOUT(8)
   ) u_b (
      .clk50(clk), .rst_n(b_rst_n), .req_valid(b_valid), .req_ready(b_ready),
      .req_port(b_port), .req_reg(b_reg), .req_data(b_data), .ym_din(b_din),
      .ym_addr(b_addr), .ym_cs_n(b_cs_n), .ym_wr_n(b_wr_n), .ym_dout(b_dout),
      .err_timeout(b_err), .err_count(b_errcnt)
   );

   int pass_cnt = 0;
   int fail_cnt = 0;
   int total_cnt = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One write on instance a; k counts cycles after the handshake edge.
   task automatic xfer_a(input logic p, input logic [7:0] r, input logic [7:0] d,
                         input int busy_end, output int k_ready, output int cs_first,
                         output int a_start, output int a_len, output int d_start,
                         output int d_len, output int gap, output int bad, output int errs);
      k_ready = -1; cs_first = -1; a_start = -1; a_len = 0;
      d_start = -1; d_len = 0; gap = 0; bad = 0; errs = 0;
      a_valid = 1'b1; a_port = p; a_reg = r; a_data = d;
      tick();
      a_valid = 1'b0; a_port = ~p; a_reg = ~r; a_data = ~d;
      for (int k = 1; k <= 5000; k++) begin
         if (a_err) errs++;
         if (a_ready) begin
            k_ready = k;
            break;
         end
         if (!a_cs_n && cs_first < 0) cs_first = k;
         if (!a_wr_n) begin
            if (a_addr[0] == 1'b0) begin
               if (a_start < 0) a_start = k;
               a_len++;
            end else begin
               if (d_start < 0) d_start = k;
               d_len++;
            end
            if (a_cs_n || a_addr[1] !== p || a_din !== (a_addr[0] ? d : r)) bad++;
         end
         if (a_cs_n && a_start >= 0 && d_start < 0) gap++;
         a_dout = (k < busy_end) ? 8'h80 : 8'h00;
         tick();
      end
   endtask

   // One write on instance b with a fixed status byte.
   task automatic xfer_b(input logic [7:0] status, output int k_ready, output int errs,
                         output int err_k);
      k_ready = -1; errs = 0; err_k = -1;
      b_dout = status;
      b_valid = 1'b1; b_port = 1'b0; b_reg = 8'h2A; b_data = 8'h55;
      tick();
      b_valid = 1'b0;
      for (int k = 1; k <= 200; k++) begin
         if (b_err) begin
            errs++;
            err_k = k;
         end
         if (b_ready) begin
            k_ready = k;
            break;
         end
         tick();
      end
   endtask

   int kr, csf, as, al, ds, dl, gp, bd, er, ek, sum;

   initial begin
      // Reset held with inputs toggling
      #1;
      a_rst_n = 1'b0;
      b_rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         a_valid = ~a_valid;
         a_data  = a_data + 8'h3C;
         a_dout  = ~a_dout;
         tick();
      end
      check("rst_cs_n", a_cs_n, 1);
      check("rst_wr_n", a_wr_n, 1);
      check("rst_ready", a_ready, 1);
      check("rst_err_count", a_errcnt, 0);
      check("rst_addr", a_addr, 0);
      check("rst_din", a_din, 0);
      check("rst_err_timeout", a_err, 0);
      a_valid = 1'b0; a_dout = 8'h00;
      a_rst_n = 1'b1;
      b_rst_n = 1'b1;
      tick();

      // Reset during the address strobe
      a_valid = 1'b1; a_port = 1'b0; a_reg = 8'h30; a_data = 8'h71; a_dout = 8'h80;
      tick();
      a_valid = 1'b0;
      repeat (9) tick();
      check("midrst_wr_low_before", a_wr_n, 0);
      #2 a_rst_n = 1'b0;
      #1;
      check("midrst_wr_n_async", a_wr_n, 1);
      check("midrst_cs_n_async", a_cs_n, 1);
      check("midrst_ready_async", a_ready, 1);
      tick();
      a_rst_n = 1'b1;
      a_dout = 8'h00;
      tick();
      check("midrst_no_error", a_errcnt, 0);

      // Port 0 single write, busy already clear
      xfer_a(1'b0, 8'h28, 8'hF0, 0, kr, csf, as, al, ds, dl, gp, bd, er);
      check("w1_cs_first", csf, 1);
      check("w1_addr_wr_start", as, 7);
      check("w1_addr_wr_len", al, 12);
      check("w1_gap", gp, 1);
      check("w1_data_wr_start", ds, 32);
      check("w1_data_wr_len", dl, 12);
      check("w1_bus_values", bd, 0);
      check("w1_occupancy", kr - 1, 62);
      check("w1_no_err", er, 0);
      check("w1_last_addr", a_addr, 1);
      check("w1_last_din", a_din, 8'hF0);

      // Port 1 write, then back-to-back on the first ready cycle
      xfer_a(1'b1, 8'hA4, 8'h22, 0, kr, csf, as, al, ds, dl, gp, bd, er);
      check("w2_bus_values", bd, 0);
      check("w2_occupancy", kr - 1, 62);
      check("w2_last_addr", a_addr, 3);
      check("w2_last_din", a_din, 8'h22);
      xfer_a(1'b1, 8'hB4, 8'hC0, 0, kr, csf, as, al, ds, dl, gp, bd, er);
      check("b2b_cs_first", csf, 1);
      check("b2b_addr_wr_start", as, 7);
      check("b2b_bus_values", bd, 0);
      check("b2b_occupancy", kr - 1, 62);

      // Busy for 40 poll cycles (POLL entry at k=62)
      xfer_a(1'b0, 8'hB0, 8'h3F, 102, kr, csf, as, al, ds, dl, gp, bd, er);
      check("busy40_ready_after_poll", kr - 62, 41);
      check("busy40_no_err", er, 0);
      check("busy40_err_count", a_errcnt, 0);
      check("busy40_bus_values", bd, 0);

      // Minimal-timing instance: best case and timeouts
      tick();
      xfer_b(8'h00, kr, er, ek);
      check("min_occupancy", kr - 1, 9);
      check("min_no_err", er, 0);
      xfer_b(8'hFF, kr, er, ek);
      check("to1_err_cycle_after_poll", ek - 9, 8);
      check("to1_err_pulses", er, 1);
      check("to1_ready", kr, 17);
      check("to1_err_count", b_errcnt, 1);
      tick();
      check("to1_pulse_one_cycle", b_err, 0);
      sum = 0;
      for (int i = 0; i < 254; i++) begin
         xfer_b(8'h80, kr, er, ek);
         sum += er;
      end
      check("to255_pulses", sum, 254);
      check("to255_err_count", b_errcnt, 255);
      xfer_b(8'h80, kr, er, ek);
      check("to256_still_pulses", er, 1);
      check("to256_saturated", b_errcnt, 255);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
